// File: rtl/accel_pkg.sv
// Shared accelerator definitions: drain FSM state encoding and index-width helper.
package accel_pkg;

    typedef enum logic [1:0] {
        DRAIN_IDLE   = 2'd0,
        DRAIN_STREAM = 2'd1,
        DRAIN_DONE   = 2'd2
    } drain_state_t;

    // Index width for a dimension, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/mac_drain.sv
// MAC array drain: snapshots the accumulator grid on start, streams it row-major, requests an array clear.
// Latency: element 0 one cycle after start, then one element per cycle; done one cycle after the last beat.
// Backpressure: out_ready low freezes index and all outputs; optional ReLU via MAC_DRAIN_RELU_EN.
module mac_drain
    import accel_pkg::*;
#(
    parameter int MAC_WIDTH = 8,
    parameter int ACC_WIDTH = 32,
    parameter int IDX_W     = clog2_min1(MAC_WIDTH)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [MAC_WIDTH*MAC_WIDTH*ACC_WIDTH-1:0] accumulators,
    output logic                                   acc_clear,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [ACC_WIDTH-1:0]                   out_data,
    output logic [IDX_W-1:0]                       out_row,
    output logic [IDX_W-1:0]                       out_col,
    output logic                                   out_last,
    output logic                                   busy,
    output logic                                   done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAC_WIDTH - 1);

    drain_state_t         state;
    logic [ACC_WIDTH-1:0] snap [MAC_WIDTH][MAC_WIDTH];
    logic [IDX_W-1:0]     row;
    logic [IDX_W-1:0]     col;
    logic [ACC_WIDTH-1:0] elem;
    logic                 streaming;
    logic                 at_last;
    logic                 xfer;

    assign streaming = (state == DRAIN_STREAM);
    assign at_last   = (row == LAST_IDX) && (col == LAST_IDX);
    assign xfer      = streaming && out_ready;
    assign elem      = snap[row][col];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DRAIN_IDLE;
            row       <= '0;
            col       <= '0;
            acc_clear <= 1'b0;
            for (int i = 0; i < MAC_WIDTH; i++) begin
                for (int j = 0; j < MAC_WIDTH; j++) begin
                    snap[i][j] <= '0;
                end
            end
        end else begin
            acc_clear <= 1'b0;
            case (state)
                DRAIN_IDLE: begin
                    if (start) begin
                        // Snapshot now so the array can be cleared and reused next cycle.
                        for (int i = 0; i < MAC_WIDTH; i++) begin
                            for (int j = 0; j < MAC_WIDTH; j++) begin
                                snap[i][j] <= accumulators[(i*MAC_WIDTH+j)*ACC_WIDTH +: ACC_WIDTH];
                            end
                        end
                        row       <= '0;
                        col       <= '0;
                        acc_clear <= 1'b1;
                        state     <= DRAIN_STREAM;
                    end
                end
                DRAIN_STREAM: begin
                    if (xfer) begin
                        if (at_last) begin
                            state <= DRAIN_DONE;
                        end else if (col == LAST_IDX) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DRAIN_DONE: begin
                    state <= DRAIN_IDLE;
                end
                default: begin
                    state <= DRAIN_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        out_valid = streaming;
        out_row   = streaming ? row : '0;
        out_col   = streaming ? col : '0;
        out_last  = streaming && at_last;
        out_data  = '0;
        if (streaming) begin
`ifdef MAC_DRAIN_RELU_EN
            out_data = elem[ACC_WIDTH-1] ? '0 : elem;
`else
            out_data = elem;
`endif
        end
        busy = (state != DRAIN_IDLE);
        done = (state == DRAIN_DONE);
    end

endmodule
